piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_pkg.sv | 13 +
 rtl/piso_bit_counter.sv | 35 +++
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing for the parallel-in serial-out serializer.
// The bit counter is sized for the widest legal word, so every WIDTH shares one counter width.
package piso_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 32;
    localparam int CNT_W     = $clog2(MAX_WIDTH);

endpackage

// File: rtl/piso_bit_counter.sv
// Bits-remaining counter: loads WIDTH-1 when a word is accepted and counts down to zero.
// A zero count while shifting marks the last bit of the word.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic dec,
    output logic is_zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    // clear overrides load, so an abort always wins over a new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with flush and gapless back-to-back words.
// serial_out / serial_valid are registered; the first bit appears the cycle after acceptance.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shreg;
    logic             cnt_zero;
    logic             last_bit;
    logic             accept;
    logic             advance;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready is combinational (IDLE, or the last bit of a SHIFT) and is forced low by flush.
    assign last_bit  = (state == SHIFT) && cnt_zero;
    assign in_ready  = !flush && ((state == IDLE) || last_bit);
    assign accept    = in_valid && in_ready;
    assign advance   = (state == SHIFT) && !last_bit && !flush;
    assign word_done = last_bit;
    assign busy      = (state == SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else if (accept) begin
            next_state = SHIFT;
        end else if (last_bit) begin
            next_state = IDLE;
        end
    end

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (accept),
        .dec     (advance),
        .is_zero (cnt_zero)
    );

    // The first bit goes straight to serial_out on acceptance; shreg keeps the bits still to send.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end else if (flush) begin
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end else if (accept) begin
            shreg        <= shift_word(in_data);
            serial_out   <= first_bit(in_data);
            serial_valid <= 1'b1;
        end else if (advance) begin
            shreg        <= shift_word(shreg);
            serial_out   <= first_bit(shreg);
            serial_valid <= 1'b1;
        end else if (last_bit) begin
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: 4-bit MSB-first table, 4-bit LSB-first order,
// asynchronous reset mid-word, and an 8-bit back-to-back run with in_data changing mid-word.
module tb_piso_serializer;

    logic clk;
    logic reset;

    logic [3:0] a_data;
    logic       a_valid, a_flush, a_ready, a_so, a_sv, a_wd, a_busy;
    logic [3:0] b_data;
    logic       b_valid, b_flush, b_ready, b_so, b_sv, b_wd, b_busy;
    logic [7:0] c_data;
    logic       c_valid, c_flush, c_ready, c_so, c_sv, c_wd, c_busy;

    int checks;
    int errors;

    typedef struct packed {
        logic       valid;
        logic [3:0] data;
        logic       flush;
        logic       so;
        logic       sv;
        logic       wd;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .flush(a_flush), .serial_out(a_so), .serial_valid(a_sv), .word_done(a_wd), .busy(a_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .flush(b_flush), .serial_out(b_so), .serial_valid(b_sv), .word_done(b_wd), .busy(b_busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .flush(c_flush), .serial_out(c_so), .serial_valid(c_sv), .word_done(c_wd), .busy(c_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic f,
                                input logic so, input logic sv, input logic wd,
                                input logic bz, input logic rd);
        vec_t r;
        r.valid = v; r.data = d; r.flush = f;
        r.so = so; r.sv = sv; r.wd = wd; r.busy = bz; r.rdy = rd;
        return r;
    endfunction

    initial begin
        logic [3:0] word;
        logic [7:0] w1;
        logic [7:0] w2;
        logic       exp_bit;

        checks = 0;
        errors = 0;
        a_data = '0; a_valid = 0; a_flush = 0;
        b_data = '0; b_valid = 0; b_flush = 0;
        c_data = '0; c_valid = 0; c_flush = 0;

        //          valid data   flush | so sv wd busy rdy
        vecs.push_back(mk(0, 4'h0, 0,   0, 0, 0, 0, 1));  // ready right after reset
        vecs.push_back(mk(1, 4'hB, 0,   0, 0, 0, 0, 1));  // accept 1011
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 1, 1, 1));
        vecs.push_back(mk(0, 4'h0, 0,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4'hB, 0,   0, 0, 0, 0, 1));  // back-to-back: 1011
        vecs.push_back(mk(1, 4'h6, 0,   1, 1, 0, 1, 0));  // then 0110 held
        vecs.push_back(mk(1, 4'h6, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'h6, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'h6, 0,   1, 1, 1, 1, 1));  // accepted on last bit
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 4'h0, 0,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4'hC, 0,   0, 0, 0, 0, 1));  // accept 1100
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 4'h1, 1,   1, 1, 0, 1, 0));  // flush on 2nd bit, word blocked
        vecs.push_back(mk(1, 4'h1, 0,   0, 0, 0, 0, 1));  // accept 0001
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 4'h0, 0,   1, 1, 1, 1, 1));
        vecs.push_back(mk(0, 4'h0, 0,   0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 4'hF, 1,   0, 0, 0, 0, 0));  // flush beats acceptance in IDLE
        vecs.push_back(mk(0, 4'h0, 0,   0, 0, 0, 0, 1));

        // Reset state
        reset = 1'b1;
        #3;
        check("reset so", a_so, 0);
        check("reset sv", a_sv, 0);
        check("reset wd", a_wd, 0);
        check("reset busy", a_busy, 0);
        check("reset c_sv", c_sv, 0);
        @(negedge clk);
        reset = 1'b0;

        // Table for the 4-bit MSB-first instance
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            a_valid = vecs[i].valid;
            a_data  = vecs[i].data;
            a_flush = vecs[i].flush;
            #1;
            check($sformatf("row%0d serial_out", i), a_so, vecs[i].so);
            check($sformatf("row%0d serial_valid", i), a_sv, vecs[i].sv);
            check($sformatf("row%0d word_done", i), a_wd, vecs[i].wd);
            check($sformatf("row%0d busy", i), a_busy, vecs[i].busy);
            check($sformatf("row%0d in_ready", i), a_ready, vecs[i].rdy);
        end
        @(negedge clk);
        a_valid = 0; a_flush = 0; a_data = '0;

        // Asynchronous reset during the 3rd bit of 1011
        @(negedge clk);
        a_valid = 1; a_data = 4'b1011;
        @(negedge clk);
        a_valid = 0; a_data = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre-reset 3rd bit", a_so, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async reset so", a_so, 0);
        check("async reset sv", a_sv, 0);
        check("async reset wd", a_wd, 0);
        check("async reset busy", a_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-reset ready", a_ready, 1);
        @(negedge clk);
        #1;
        check("post-reset no residue sv", a_sv, 0);
        check("post-reset no residue wd", a_wd, 0);
        a_valid = 1; a_data = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_valid = 0; a_data = '0;
            #1;
            check($sformatf("ones bit%0d so", i), a_so, 1);
            check($sformatf("ones bit%0d sv", i), a_sv, 1);
            check($sformatf("ones bit%0d wd", i), a_wd, (i == 3));
        end
        @(negedge clk);
        #1;
        check("ones idle sv", a_sv, 0);

        // LSB-first order
        word = 4'b1011;
        @(negedge clk);
        b_valid = 1; b_data = word;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_valid = 0; b_data = 4'b0000;
            #1;
            check($sformatf("lsb bit%0d so", i), b_so, word[i]);
            check($sformatf("lsb bit%0d sv", i), b_sv, 1);
            check($sformatf("lsb bit%0d wd", i), b_wd, (i == 3));
        end
        @(negedge clk);
        #1;
        check("lsb idle sv", b_sv, 0);
        check("lsb idle busy", b_busy, 0);

        // 8-bit: valid held, data changes mid-word, second word taken exactly on the last bit
        w1 = 8'hA5;
        w2 = 8'h3C;
        @(negedge clk);
        c_valid = 1; c_data = w1;
        #1;
        check("w8 idle ready", c_ready, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            c_data  = (i < 3) ? 8'hFF : w2;
            c_valid = (i < 8);
            #1;
            exp_bit = (i < 8) ? w1[7 - i] : w2[15 - i];
            check($sformatf("w8 bit%0d so", i), c_so, exp_bit);
            check($sformatf("w8 bit%0d sv", i), c_sv, 1);
            check($sformatf("w8 bit%0d wd", i), c_wd, (i == 7 || i == 15));
            check($sformatf("w8 bit%0d ready", i), c_ready, (i == 7 || i == 15));
        end
        @(negedge clk);
        c_valid = 0;
        #1;
        check("w8 idle sv", c_sv, 0);
        check("w8 idle busy", c_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
